// File: rtl/det_window_sequencer_pkg.sv
// Shared types and helpers for the detector window sequencer.
package det_window_sequencer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_COUNT,
    ST_HOLD
  } state_e;

  // Depth of the detector's synchroniser pipeline; settle time must cover it.
  localparam int SETTLE_MIN = 6;

  function automatic logic [31:0] sat_inc(input logic [31:0] value,
                                          input logic [31:0] max_val,
                                          input logic        inc);
    return (inc && (value != max_val)) ? value + 32'd1 : value;
  endfunction

endpackage

// File: rtl/det_window_sequencer_sat_counter.sv
// Saturating pulse counter; value/sat include the current cycle's increment
// so the owner can snapshot a window on the same edge that clears it.
module det_window_sequencer_sat_counter
  import det_window_sequencer_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             inc,
  output logic [CNT_W-1:0] value,
  output logic             sat
);

  localparam logic [CNT_W-1:0] MAX_VAL = '1;

  logic [CNT_W-1:0] value_q, value_d;

  always_comb begin
    value   = CNT_W'(sat_inc(32'(value_q), 32'(MAX_VAL), inc));
    sat     = (value == MAX_VAL);
    value_d = clear ? '0 : value;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) value_q <= '0;
    else        value_q <= value_d;
  end

endmodule

// File: rtl/det_window_sequencer.sv
// Arms the dual edge detector, waits out its synchroniser, then counts
// detA/detB/coincident pulses over timed windows and hands results out.
//
// state  | meaning
// IDLE   | waiting for start; veto_last holds last armed value
// SETTLE | detector pipeline flushing, pulses ignored
// COUNT  | window open, pulses counted
// HOLD   | window closed, result waiting for a free output register
module det_window_sequencer
  import det_window_sequencer_pkg::*;
#(
  parameter int CNT_W      = 16,
  parameter int WIN_W      = 24,
  parameter int SETTLE_CYC = 8,
  parameter int IDX_W      = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             stop,
  input  logic [WIN_W-1:0] win_len,
  input  logic [IDX_W-1:0] n_windows,
  input  logic [2:0]       veto_cfg,
  input  logic             detA,
  input  logic             detB,
  output logic [2:0]       veto_last,
  output logic             busy,
  output logic             win_active,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [CNT_W-1:0] res_cnt_a,
  output logic [CNT_W-1:0] res_cnt_b,
  output logic [CNT_W-1:0] res_cnt_ab,
  output logic [IDX_W-1:0] res_idx,
  output logic             res_ovf,
  output logic             res_last
);

  localparam int SET_W = $clog2(SETTLE_CYC);

  if (SETTLE_CYC < SETTLE_MIN) begin : g_settle_too_short
    $error("SETTLE_CYC shorter than the detector synchroniser depth");
  end

  state_e           state_q, state_d;
  logic [SET_W-1:0] settle_q, settle_d;
  logic [WIN_W-1:0] win_cnt_q, win_cnt_d, win_m1_q, win_m1_d;
  logic [IDX_W-1:0] n_win_q, n_win_d, idx_q, idx_d, res_idx_q, res_idx_d;
  logic [2:0]       veto_q, veto_d;
  logic [CNT_W-1:0] res_cnt_a_q, res_cnt_a_d, res_cnt_b_q, res_cnt_b_d;
  logic [CNT_W-1:0] res_cnt_ab_q, res_cnt_ab_d;
  logic             res_valid_q, res_valid_d, res_ovf_q, res_ovf_d;
  logic             res_last_q, res_last_d;

  logic             clr, load, counting, reg_free, last_win;
  logic [CNT_W-1:0] cnt_a, cnt_b, cnt_ab;
  logic             sat_a, sat_b, sat_ab;

  assign counting = (state_q == ST_COUNT);
  assign reg_free = !res_valid_q || res_ready;
  assign last_win = (n_win_q != '0) && (idx_q == n_win_q - IDX_W'(1));

  det_window_sequencer_sat_counter #(.CNT_W(CNT_W)) u_cnt_a (
    .clk(clk), .rst_n(rst_n), .clear(clr), .inc(detA && counting),
    .value(cnt_a), .sat(sat_a)
  );
  det_window_sequencer_sat_counter #(.CNT_W(CNT_W)) u_cnt_b (
    .clk(clk), .rst_n(rst_n), .clear(clr), .inc(detB && counting),
    .value(cnt_b), .sat(sat_b)
  );
  det_window_sequencer_sat_counter #(.CNT_W(CNT_W)) u_cnt_ab (
    .clk(clk), .rst_n(rst_n), .clear(clr), .inc(detA && detB && counting),
    .value(cnt_ab), .sat(sat_ab)
  );

  always_comb begin
    state_d      = state_q;
    settle_d     = settle_q;
    win_cnt_d    = win_cnt_q;
    win_m1_d     = win_m1_q;
    n_win_d      = n_win_q;
    idx_d        = idx_q;
    veto_d       = veto_q;
    res_valid_d  = res_valid_q;
    res_cnt_a_d  = res_cnt_a_q;
    res_cnt_b_d  = res_cnt_b_q;
    res_cnt_ab_d = res_cnt_ab_q;
    res_idx_d    = res_idx_q;
    res_ovf_d    = res_ovf_q;
    res_last_d   = res_last_q;
    clr          = 1'b0;
    load         = 1'b0;

    if (res_valid_q && res_ready) res_valid_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start && !stop) begin
          win_m1_d = (win_len == '0) ? '0 : win_len - WIN_W'(1);
          n_win_d  = n_windows;
          veto_d   = veto_cfg;
          settle_d = SET_W'(SETTLE_CYC - 1);
          idx_d    = '0;
          state_d  = ST_SETTLE;
        end
      end
      ST_SETTLE: begin
        if (stop) begin
          state_d = ST_IDLE;
        end else if (settle_q == '0) begin
          clr       = 1'b1;
          win_cnt_d = win_m1_q;
          state_d   = ST_COUNT;
        end else begin
          settle_d = settle_q - SET_W'(1);
        end
      end
      ST_COUNT: begin
        if (stop) begin
          state_d = ST_IDLE;
        end else if (win_cnt_q == '0) begin
          if (reg_free) load = 1'b1;
          else          state_d = ST_HOLD;
        end else begin
          win_cnt_d = win_cnt_q - WIN_W'(1);
        end
      end
      ST_HOLD: begin
        if (stop)          state_d = ST_IDLE;
        else if (reg_free) load = 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase

    // Next window starts on the load edge itself, so no dead cycles when ready.
    if (load) begin
      res_valid_d  = 1'b1;
      res_cnt_a_d  = cnt_a;
      res_cnt_b_d  = cnt_b;
      res_cnt_ab_d = cnt_ab;
      res_ovf_d    = sat_a || sat_b || sat_ab;
      res_idx_d    = idx_q;
      res_last_d   = last_win;
      idx_d        = idx_q + IDX_W'(1);
      if (last_win) begin
        state_d = ST_IDLE;
      end else begin
        clr       = 1'b1;
        win_cnt_d = win_m1_q;
        state_d   = ST_COUNT;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      settle_q     <= '0;
      win_cnt_q    <= '0;
      win_m1_q     <= '0;
      n_win_q      <= '0;
      idx_q        <= '0;
      veto_q       <= '0;
      res_valid_q  <= 1'b0;
      res_cnt_a_q  <= '0;
      res_cnt_b_q  <= '0;
      res_cnt_ab_q <= '0;
      res_idx_q    <= '0;
      res_ovf_q    <= 1'b0;
      res_last_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      settle_q     <= settle_d;
      win_cnt_q    <= win_cnt_d;
      win_m1_q     <= win_m1_d;
      n_win_q      <= n_win_d;
      idx_q        <= idx_d;
      veto_q       <= veto_d;
      res_valid_q  <= res_valid_d;
      res_cnt_a_q  <= res_cnt_a_d;
      res_cnt_b_q  <= res_cnt_b_d;
      res_cnt_ab_q <= res_cnt_ab_d;
      res_idx_q    <= res_idx_d;
      res_ovf_q    <= res_ovf_d;
      res_last_q   <= res_last_d;
    end
  end

  assign veto_last  = veto_q;
  assign busy       = (state_q != ST_IDLE);
  assign win_active = counting;
  assign res_valid  = res_valid_q;
  assign res_cnt_a  = res_cnt_a_q;
  assign res_cnt_b  = res_cnt_b_q;
  assign res_cnt_ab = res_cnt_ab_q;
  assign res_idx    = res_idx_q;
  assign res_ovf    = res_ovf_q;
  assign res_last   = res_last_q;

endmodule

// File: tb/tb_det_window_sequencer.sv
// Directed bench for det_window_sequencer: table of single-window runs plus
// hand-written multi-window, backpressure, saturation, abort and reset cases.
module tb_det_window_sequencer;

  localparam int CNT_W = 16;
  localparam int WIN_W = 24;
  localparam int IDX_W = 8;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0, start4 = 1'b0, stop = 1'b0;
  logic             res_ready = 1'b0, detA = 1'b0, detB = 1'b0;
  logic [WIN_W-1:0] win_len = '0;
  logic [IDX_W-1:0] n_windows = '0;
  logic [2:0]       veto_cfg = '0;

  logic [2:0]       veto_last, veto_last4;
  logic             busy, win_active, res_valid, res_ovf, res_last;
  logic             busy4, win_active4, res_valid4, res_ovf4, res_last4;
  logic [CNT_W-1:0] res_cnt_a, res_cnt_b, res_cnt_ab;
  logic [3:0]       res_cnt_a4, res_cnt_b4, res_cnt_ab4;
  logic [IDX_W-1:0] res_idx, res_idx4;

  always #5 clk = ~clk;

  det_window_sequencer #(.CNT_W(CNT_W), .WIN_W(WIN_W), .SETTLE_CYC(8), .IDX_W(IDX_W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .win_len(win_len),
    .n_windows(n_windows), .veto_cfg(veto_cfg), .detA(detA), .detB(detB),
    .veto_last(veto_last), .busy(busy), .win_active(win_active),
    .res_valid(res_valid), .res_ready(res_ready), .res_cnt_a(res_cnt_a),
    .res_cnt_b(res_cnt_b), .res_cnt_ab(res_cnt_ab), .res_idx(res_idx),
    .res_ovf(res_ovf), .res_last(res_last)
  );

  // Narrow-counter instance for the saturation case, minimum settle time.
  det_window_sequencer #(.CNT_W(4), .WIN_W(WIN_W), .SETTLE_CYC(6), .IDX_W(IDX_W)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .stop(stop), .win_len(win_len),
    .n_windows(n_windows), .veto_cfg(veto_cfg), .detA(detA), .detB(detB),
    .veto_last(veto_last4), .busy(busy4), .win_active(win_active4),
    .res_valid(res_valid4), .res_ready(res_ready), .res_cnt_a(res_cnt_a4),
    .res_cnt_b(res_cnt_b4), .res_cnt_ab(res_cnt_ab4), .res_idx(res_idx4),
    .res_ovf(res_ovf4), .res_last(res_last4)
  );

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    int         win;
    logic [2:0] veto;
    int         a0, na, b0, nb;
    int         ea, eb, eab;
  } vec_t;

  typedef struct {
    int cyc;
    int cnt_a;
    int idx;
    int last;
  } hs_t;

  vec_t vecs[5];
  hs_t  got_q[$];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic collect(input int first, input int n);
    for (int c = first; c < first + n; c++) begin
      if (res_valid && res_ready)
        got_q.push_back('{c, int'(res_cnt_a), int'(res_idx), int'(res_last)});
      tick();
    end
  endtask

  task automatic check_hs(input string tag, input int i, input int ecyc,
                          input int ecnt, input int eidx, input int elast);
    chk({tag, "_present"}, 32'(got_q.size() > i), 32'd1);
    if (got_q.size() > i) begin
      chk({tag, "_cycle"}, 32'(got_q[i].cyc), 32'(ecyc));
      chk({tag, "_cnt_a"}, 32'(got_q[i].cnt_a), 32'(ecnt));
      chk({tag, "_idx"}, 32'(got_q[i].idx), 32'(eidx));
      chk({tag, "_last"}, 32'(got_q[i].last), 32'(elast));
    end
  endtask

  // Start in cycle 0; settle 1..8; window 9..8+L; result expected in 9+L.
  task automatic run_vec(input vec_t v);
    int len;
    len       = (v.win == 0) ? 1 : v.win;
    veto_cfg  = v.veto;
    win_len   = WIN_W'(v.win);
    n_windows = IDX_W'(1);
    start     = 1'b1;
    tick();
    start    = 1'b0;
    veto_cfg = ~v.veto;
    detA     = 1'b1;
    detB     = 1'b1;
    chk("vec_veto_armed", 32'(veto_last), 32'(v.veto));
    chk("vec_busy", 32'(busy), 32'd1);
    repeat (7) tick();
    chk("vec_settle_closed", 32'(win_active), 32'd0);
    for (int k = 0; k < len; k++) begin
      tick();
      detA = (k >= v.a0) && (k < v.a0 + v.na);
      detB = (k >= v.b0) && (k < v.b0 + v.nb);
      if (k == 0) chk("vec_win_open", 32'(win_active), 32'd1);
      if (k == len - 1) chk("vec_valid_early", 32'(res_valid), 32'd0);
    end
    tick();
    detA = 1'b1;
    detB = 1'b1;
    chk("vec_valid", 32'(res_valid), 32'd1);
    chk("vec_cnt_a", 32'(res_cnt_a), 32'(v.ea));
    chk("vec_cnt_b", 32'(res_cnt_b), 32'(v.eb));
    chk("vec_cnt_ab", 32'(res_cnt_ab), 32'(v.eab));
    chk("vec_idx", 32'(res_idx), 32'd0);
    chk("vec_last", 32'(res_last), 32'd1);
    chk("vec_ovf", 32'(res_ovf), 32'd0);
    chk("vec_idle", 32'(busy), 32'd0);
    chk("vec_veto_held", 32'(veto_last), 32'(v.veto));
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    detA = 1'b0;
    detB = 1'b0;
    chk("vec_consumed", 32'(res_valid), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: got no finish, expected finish before 1ms");
    $fatal(1);
  end

  initial begin
    int  cyc;
    logic seen;

    //        win  veto    a0 na  b0 nb  ea eb eab
    vecs[0] = '{100, 3'b101, 10, 10, 18, 4, 10, 4, 2};
    vecs[1] = '{0,   3'b010, 0,  1,  0,  1, 1,  1, 1};
    vecs[2] = '{7,   3'b111, 0,  7,  3,  4, 7,  4, 4};
    vecs[3] = '{20,  3'b000, 0,  0,  0,  0, 0,  0, 0};
    vecs[4] = '{3,   3'b011, 2,  5,  0,  2, 1,  2, 0};

    repeat (2) @(posedge clk);
    #1;
    chk("rst_veto", 32'(veto_last), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_win_active", 32'(win_active), 32'd0);
    chk("rst_valid", 32'(res_valid), 32'd0);
    chk("rst_cnt_a", 32'(res_cnt_a), 32'd0);
    chk("rst_idx", 32'(res_idx), 32'd0);
    chk("rst_last", 32'(res_last), 32'd0);
    chk("rst_ovf", 32'(res_ovf), 32'd0);
    rst_n = 1'b1;
    tick();

    foreach (vecs[i]) run_vec(vecs[i]);

    // Back-to-back windows, always-ready consumer.
    got_q.delete();
    res_ready = 1'b1; detA = 1'b1; detB = 1'b0;
    win_len = WIN_W'(5); n_windows = IDX_W'(3); veto_cfg = 3'b001;
    start = 1'b1;
    tick();
    start = 1'b0;
    collect(1, 30);
    chk("b2b_count", 32'(got_q.size()), 32'd3);
    for (int i = 0; i < 3; i++) check_hs("b2b", i, 14 + 5 * i, 5, i, (i == 2) ? 1 : 0);
    chk("b2b_idle", 32'(busy), 32'd0);

    // Backpressure: second window ends into a full register and waits in HOLD.
    res_ready = 1'b0; detA = 1'b1;
    win_len = WIN_W'(4); n_windows = IDX_W'(2);
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (12) tick();
    chk("bp_valid0", 32'(res_valid), 32'd1);
    chk("bp_cnt0", 32'(res_cnt_a), 32'd4);
    chk("bp_idx0", 32'(res_idx), 32'd0);
    chk("bp_last0", 32'(res_last), 32'd0);
    for (int c = 14; c <= 19; c++) begin
      tick();
      chk("bp_stable_valid", 32'(res_valid), 32'd1);
      chk("bp_stable_cnt", 32'(res_cnt_a), 32'd4);
      chk("bp_stable_idx", 32'(res_idx), 32'd0);
      if (c == 18) begin
        chk("bp_hold_closed", 32'(win_active), 32'd0);
        chk("bp_hold_busy", 32'(busy), 32'd1);
      end
    end
    tick();
    res_ready = 1'b1;
    tick();
    chk("bp_valid1", 32'(res_valid), 32'd1);
    chk("bp_cnt1", 32'(res_cnt_a), 32'd4);
    chk("bp_idx1", 32'(res_idx), 32'd1);
    chk("bp_last1", 32'(res_last), 32'd1);
    chk("bp_idle", 32'(busy), 32'd0);
    tick();
    chk("bp_drained", 32'(res_valid), 32'd0);
    res_ready = 1'b0; detA = 1'b0;

    // Saturation on the 4-bit instance: 6 settle + 40 window + 1.
    detA = 1'b1; detB = 1'b0;
    win_len = WIN_W'(40); n_windows = IDX_W'(1); veto_cfg = 3'b100;
    start4 = 1'b1;
    tick();
    start4 = 1'b0;
    cyc = 1;
    while (!res_valid4 && cyc < 100) begin
      tick();
      cyc++;
    end
    chk("sat_latency", 32'(cyc), 32'd47);
    chk("sat_cnt_a", 32'(res_cnt_a4), 32'd15);
    chk("sat_cnt_b", 32'(res_cnt_b4), 32'd0);
    chk("sat_cnt_ab", 32'(res_cnt_ab4), 32'd0);
    chk("sat_ovf", 32'(res_ovf4), 32'd1);
    chk("sat_idx", 32'(res_idx4), 32'd0);
    chk("sat_last", 32'(res_last4), 32'd1);
    chk("sat_veto", 32'(veto_last4), 32'd4);
    chk("sat_idle", 32'(busy4 || win_active4), 32'd0);
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0; detA = 1'b0;

    // Abort in the third COUNT cycle.
    win_len = WIN_W'(10); n_windows = IDX_W'(1); detA = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (10) tick();
    chk("abort_in_window", 32'(win_active), 32'd1);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_closed", 32'(win_active), 32'd0);
    seen = 1'b0;
    repeat (15) begin
      tick();
      if (res_valid) seen = 1'b1;
    end
    chk("abort_no_result", 32'(seen), 32'd0);

    start = 1'b1; stop = 1'b1;
    tick();
    start = 1'b0; stop = 1'b0;
    chk("collide_idle", 32'(busy), 32'd0);

    // A second start mid-run must not restart or re-arm.
    veto_cfg = 3'b011; win_len = WIN_W'(5); detA = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    start = 1'b1; veto_cfg = 3'b100; win_len = WIN_W'(2);
    tick();
    start = 1'b0;
    chk("rearm_veto", 32'(veto_last), 32'd3);
    repeat (9) tick();
    chk("rearm_not_yet", 32'(res_valid), 32'd0);
    tick();
    chk("rearm_valid", 32'(res_valid), 32'd1);
    chk("rearm_cnt_a", 32'(res_cnt_a), 32'd5);

    // Stop while an unaccepted result is pending keeps that result.
    veto_cfg = 3'b101;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    stop = 1'b1;
    tick();
    stop = 1'b0;
    chk("stop_pend_busy", 32'(busy), 32'd0);
    chk("stop_pend_valid", 32'(res_valid), 32'd1);
    chk("stop_pend_cnt", 32'(res_cnt_a), 32'd5);
    chk("stop_pend_veto", 32'(veto_last), 32'd5);
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0; detA = 1'b0;
    chk("stop_pend_drained", 32'(res_valid), 32'd0);

    // Async reset mid-COUNT with a result pending.
    veto_cfg = 3'b110; win_len = WIN_W'(4); n_windows = IDX_W'(2); detA = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (14) tick();
    chk("prerst_valid", 32'(res_valid), 32'd1);
    chk("prerst_window", 32'(win_active), 32'd1);
    #3;
    rst_n = 1'b0;
    #1;
    chk("arst_valid", 32'(res_valid), 32'd0);
    chk("arst_veto", 32'(veto_last), 32'd0);
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_win_active", 32'(win_active), 32'd0);
    chk("arst_cnt_a", 32'(res_cnt_a), 32'd0);
    chk("arst_last", 32'(res_last), 32'd0);
    #2;
    rst_n = 1'b1;
    tick();

    // Fresh run after reset with win_len=0 -> 1-cycle windows.
    got_q.delete();
    veto_cfg = 3'b001; win_len = '0; n_windows = IDX_W'(2);
    res_ready = 1'b1; detA = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    collect(1, 20);
    chk("w0_count", 32'(got_q.size()), 32'd2);
    check_hs("w0", 0, 10, 1, 0, 0);
    check_hs("w0", 1, 11, 1, 1, 1);
    chk("w0_veto", 32'(veto_last), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
